// File: rtl/bus_pkg.sv
// Shared definitions for the serial slave port: FSM state type/encodings and default widths.
package bus_pkg;

    localparam int unsigned DefAdn = 12;
    localparam int unsigned DefN   = 8;

    typedef logic [3:0] slave_state_t;

    localparam slave_state_t StIdle   = 4'd0;
    localparam slave_state_t StAddr   = 4'd1;
    localparam slave_state_t StWdata  = 4'd2;
    localparam slave_state_t StWrite  = 4'd3;
    localparam slave_state_t StRdelay = 4'd4;
    localparam slave_state_t StRfetch = 4'd5;
    localparam slave_state_t StRdata  = 4'd6;
    localparam slave_state_t StDone   = 4'd7;

endpackage

// File: rtl/slave_bram.sv
// Single-port local storage with synchronous read; contents are never reset.
module slave_bram #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1 << AW) - 1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else begin
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/serial_slave_port.sv
// Bit-serial slave: LSB-first address/data in, delayed serial read-back out.
// Burst transfers are built only when SERIAL_SLAVE_PORT_BURST_EN is defined.
module serial_slave_port
    import bus_pkg::*;
#(
    parameter int unsigned ADN       = DefAdn,
    parameter int unsigned N         = DefN,
    parameter int unsigned MEM_AW    = 8,
    parameter int unsigned DelayN    = 20,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       validIn,
    input  logic       wren,
    input  logic       Address,
    input  logic       DataIn,
    input  logic       BurstEn,
    input  logic       BusAvailable,
    output logic       ready,
    output logic       validOut,
    output logic       hold,
    output logic       DataOut,
    output logic [3:0] state_out
);

    localparam int unsigned BitMax = (ADN > N) ? ADN : N;
    localparam int unsigned CntW   = $clog2(BitMax + 1);
    localparam int unsigned DlyW   = (DelayN > 0) ? $clog2(DelayN + 1) : 1;
    localparam slave_state_t ReadEntry = (DelayN == 0) ? StRfetch : StRdelay;

    slave_state_t    state_q, state_d;
    logic [ADN-1:0]  addr_q, addr_d;
    logic [N-1:0]    wdata_q, wdata_d;
    logic [N-1:0]    rdata_q, rdata_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DlyW-1:0] dly_q, dly_d;
    logic            fetch_q, fetch_d;

    logic          addr_last;
    logic          word_done;
    logic          more_words;
    logic          mem_we;
    logic [N-1:0]  mem_rdata;

    assign addr_last = ((state_q == StIdle) || (state_q == StAddr)) && validIn &&
                       (bit_cnt_q == CntW'(ADN - 1));

`ifdef SERIAL_SLAVE_PORT_BURST_EN
    localparam int unsigned WcW = $clog2(BURST_LEN + 1);

    logic           burst_q;
    logic [WcW-1:0] word_q;

    assign more_words = burst_q && (word_q < WcW'(BURST_LEN - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            burst_q <= 1'b0;
            word_q  <= '0;
        end else if (addr_last) begin
            burst_q <= BurstEn;
            word_q  <= '0;
        end else if (word_done && more_words) begin
            word_q <= word_q + WcW'(1);
        end
    end
`else
    logic unused_burst_en;
    assign unused_burst_en = BurstEn;
    assign more_words      = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        bit_cnt_d = bit_cnt_q;
        dly_d     = dly_q;
        fetch_d   = fetch_q;
        word_done = 1'b0;

        case (state_q)
            StIdle, StAddr: begin
                if (validIn) begin
                    addr_d    = {Address, addr_q[ADN-1:1]};
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                    state_d   = StAddr;
                    if (addr_last) begin
                        bit_cnt_d = '0;
                        state_d   = wren ? StWdata : ReadEntry;
                    end
                end
            end
            StWdata: begin
                if (validIn) begin
                    wdata_d   = {DataIn, wdata_q[N-1:1]};
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                    if (bit_cnt_q == CntW'(N - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = StWrite;
                    end
                end
            end
            StWrite: begin
                word_done = 1'b1;
                state_d   = more_words ? StWdata : StDone;
            end
            StRdelay: begin
                dly_d = dly_q + DlyW'(1);
                if (dly_q == DlyW'(DelayN - 1)) begin
                    dly_d   = '0;
                    state_d = StRfetch;
                end
            end
            StRfetch: begin
                // First cycle presents the address; second captures the registered read data.
                fetch_d = 1'b1;
                if (fetch_q) begin
                    fetch_d = 1'b0;
                    rdata_d = mem_rdata;
                    state_d = StRdata;
                end
            end
            StRdata: begin
                if (BusAvailable) begin
                    rdata_d   = {1'b0, rdata_q[N-1:1]};
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                    if (bit_cnt_q == CntW'(N - 1)) begin
                        bit_cnt_d = '0;
                        word_done = 1'b1;
                        state_d   = more_words ? ReadEntry : StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (word_done && more_words) begin
            addr_d[MEM_AW-1:0] = addr_q[MEM_AW-1:0] + MEM_AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            bit_cnt_q <= '0;
            dly_q     <= '0;
            fetch_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            bit_cnt_q <= bit_cnt_d;
            dly_q     <= dly_d;
            fetch_q   <= fetch_d;
        end
    end

    // Gate with reset so an edge that resets out of WRITE does not commit the word.
    assign mem_we = (state_q == StWrite) && reset;

    slave_bram #(
        .AW (MEM_AW),
        .DW (N)
    ) u_bram (
        .clk_i   (clk),
        .we_i    (mem_we),
        .addr_i  (addr_q[MEM_AW-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    assign ready     = (state_q == StIdle);
    assign hold      = (state_q == StRdelay);
    assign validOut  = (state_q == StRdata) && BusAvailable;
    assign DataOut   = validOut && rdata_q[0];
    assign state_out = state_q;

endmodule

// File: tb/tb_serial_slave_port.sv
// Randomised scoreboard bench for serial_slave_port against a word-level memory model.
module tb_serial_slave_port;

    localparam int unsigned ADN       = 12;
    localparam int unsigned N         = 8;
    localparam int unsigned MEM_AW    = 8;
    localparam int unsigned DelayN    = 20;
    localparam int unsigned BURST_LEN = 4;
`ifdef SERIAL_SLAVE_PORT_BURST_EN
    localparam bit BurstOn = 1'b1;
`else
    localparam bit BurstOn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       validIn = 1'b0;
    logic       wren = 1'b0;
    logic       Address = 1'b0;
    logic       DataIn = 1'b0;
    logic       BurstEn = 1'b0;
    logic       BusAvailable = 1'b1;
    logic       ready, validOut, hold, DataOut;
    logic [3:0] state_out;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int low_from = -1;
    int low_to = -1;
    bit bus_rand = 1'b0;
    int stray = 0;

    logic [N-1:0] mem_m [256];
    logic [N-1:0] exp_q [$];

    serial_slave_port #(
        .ADN       (ADN),
        .N         (N),
        .MEM_AW    (MEM_AW),
        .DelayN    (DelayN),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .validIn      (validIn),
        .wren         (wren),
        .Address      (Address),
        .DataIn       (DataIn),
        .BurstEn      (BurstEn),
        .BusAvailable (BusAvailable),
        .ready        (ready),
        .validOut     (validOut),
        .hold         (hold),
        .DataOut      (DataOut),
        .state_out    (state_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return-path arbiter: random grants, plus an optional forced-low window.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cyc >= low_from && cyc < low_to) BusAvailable = 1'b0;
            else if (bus_rand) BusAvailable = ($urandom_range(0, 3) != 0);
            else BusAvailable = 1'b1;
        end
    end

    // Monitor: assembles serial read words, pops expected, checks pulse/latency widths.
    initial begin
        int nb = 0;
        int hold_run = 0;
        int wr_run = 0;
        int done_run = 0;
        logic [N-1:0] w = '0;
        logic [N-1:0] e;
        forever begin
            @(negedge clk);
            if (validOut === 1'b1 && state_out !== 4'd6) stray++;
            if (DataOut === 1'b1 && validOut !== 1'b1) stray++;
            if (validOut === 1'b1) begin
                w[nb] = DataOut;
                nb++;
                if (nb == N) begin
                    nb = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_read_word: got %0h, expected none", w);
                    end else begin
                        e = exp_q.pop_front();
                        check("read_word", 32'(w), 32'(e));
                    end
                end
            end
            if (hold === 1'b1) hold_run++;
            else if (hold_run > 0) begin
                check("hold_cycles", hold_run, DelayN);
                hold_run = 0;
            end
            if (state_out === 4'd3) wr_run++;
            else if (wr_run > 0) begin
                check("write_pulse_cycles", wr_run, 1);
                wr_run = 0;
            end
            if (state_out === 4'd7) done_run++;
            else if (done_run > 0) begin
                check("done_cycles", done_run, 1);
                done_run = 0;
            end
        end
    end

    task automatic wait_state(input logic [3:0] st, input int bound, input string name);
        int n = 0;
        while (state_out !== st && n < bound) begin
            tick();
            n++;
        end
        check(name, 32'(state_out), 32'(st));
    endtask

    task automatic wait_ready(input int bound);
        int n = 0;
        while (ready !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check("ready_return", 32'(ready), 1);
    endtask

    task automatic send_bits(input logic [31:0] val, input int nbits, input bit is_addr,
                             input int gap_at, input int gap_len, input bit rand_gaps);
        int i = 0;
        int g = 0;
        while (i < nbits) begin
            if (i == gap_at && g < gap_len) begin
                validIn = 1'b0;
                g++;
            end else if (rand_gaps && $urandom_range(0, 4) == 0) begin
                validIn = 1'b0;
            end else begin
                validIn = 1'b1;
                if (is_addr) Address = val[i];
                else DataIn = val[i];
                i++;
            end
            tick();
        end
        validIn = 1'b0;
    endtask

    function automatic int nwords(input bit burst);
        return (BurstOn && burst) ? BURST_LEN : 1;
    endfunction

    task automatic write_txn(input logic [ADN-1:0] addr, input bit burst, input logic [31:0] data,
                             input int gap_at, input bit rand_gaps);
        int nw = nwords(burst);
        for (int k = 0; k < nw; k++) mem_m[(int'(addr[7:0]) + k) % 256] = data[8*k +: 8];
        wait_ready(200);
        wren = 1'b1;
        BurstEn = burst;
        send_bits(32'(addr), ADN, 1'b1, gap_at, 3, rand_gaps);
        for (int k = 0; k < nw; k++) begin
            wait_state(4'd2, 50, "enter_wdata");
            send_bits(32'(data[8*k +: 8]), N, 1'b0, -1, 0, rand_gaps);
        end
        wait_ready(50);
    endtask

    task automatic read_txn(input logic [ADN-1:0] addr, input bit burst, input int gap_at,
                            input bit rand_gaps);
        int nw = nwords(burst);
        for (int k = 0; k < nw; k++) exp_q.push_back(mem_m[(int'(addr[7:0]) + k) % 256]);
        wait_ready(200);
        wren = 1'b0;
        BurstEn = burst;
        send_bits(32'(addr), ADN, 1'b1, gap_at, 3, rand_gaps);
        wait_ready(3000);
    endtask

    initial begin
        logic [N-1:0] old;
        // Reset state
        tick();
        tick();
        check("rst_ready", 32'(ready), 1);
        check("rst_valid_out", 32'(validOut), 0);
        check("rst_hold", 32'(hold), 0);
        check("rst_data_out", 32'(DataOut), 0);
        check("rst_state", 32'(state_out), 0);
        reset = 1'b1;
        tick();

        // Fill every word so later reads are fully defined.
        for (int a = 0; a < 256; a++) begin
            write_txn({4'($urandom_range(0, 15)), 8'(a)}, 1'b0, 32'($urandom), -1, 1'b0);
        end

        // Directed write then read of 0x005.
        write_txn(12'h005, 1'b0, 32'h0000_00A5, -1, 1'b0);
        read_txn(12'h005, 1'b0, -1, 1'b0);

        // Address stall of 3 cycles, and a 2-cycle grant drop mid-word.
        write_txn(12'h0A3, 1'b0, 32'h0000_003C, 5, 1'b0);
        fork
            read_txn(12'h0A3, 1'b0, 7, 1'b0);
            begin
                wait_state(4'd6, 400, "reach_rdata");
                low_from = cyc + 3;
                low_to = cyc + 5;
            end
        join

        // Burst write across the wrap point, then single-word read-back.
        write_txn(12'h0FE, 1'b1, 32'h4433_2211, -1, 1'b0);
        read_txn(12'h0FE, 1'b0, -1, 1'b0);
        read_txn(12'h0FF, 1'b0, -1, 1'b0);
        read_txn(12'h000, 1'b0, -1, 1'b0);
        read_txn(12'h001, 1'b0, -1, 1'b0);
        read_txn(12'h3FE, 1'b1, -1, 1'b0);

        // Reset in WDATA after 4 bits: abort with target word unchanged.
        old = mem_m[8'h40];
        wait_ready(200);
        wren = 1'b1;
        BurstEn = 1'b0;
        send_bits(32'h040, ADN, 1'b1, -1, 0, 1'b0);
        send_bits(32'(~old), 4, 1'b0, -1, 0, 1'b0);
        check("pre_reset_state", 32'(state_out), 2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_state", 32'(state_out), 0);
        check("abort_ready", 32'(ready), 1);
        check("abort_hold", 32'(hold), 0);
        check("abort_valid_out", 32'(validOut), 0);
        tick();
        read_txn(12'h040, 1'b0, -1, 1'b0);

        // Randomised traffic with input gaps and grant jitter.
        bus_rand = 1'b1;
        for (int t = 0; t < 40; t++) begin
            logic [ADN-1:0] a = ADN'($urandom);
            bit b = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) write_txn(a, b, $urandom, -1, 1'b1);
            else read_txn(a, b, -1, 1'b1);
        end
        bus_rand = 1'b0;
        tick();
        tick();

        check("scoreboard_drained", exp_q.size(), 0);
        check("stray_valid_out", stray, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
